sqrt_seq_unit: RTL and testbench
================================

# sqrt_seq_unit

Parametrised sequential integer square-root unit. It combines the three-part controller organisation (next-state logic, state register, output decode) with its own datapath. It computes floor(sqrt(X)) and the remainder X − root² for a WIDTH-bit unsigned radicand, producing one root bit per clock. A Start/Done level handshake connects it to the surrounding control logic.

## Interface
- WIDTH, 16, radicand width in bits; must be even and ≥ 4 (elaboration error otherwise); N = WIDTH/2 iterations
- clk  input  1  rising-edge clock
- CLR  input  1  asynchronous, active-high reset
- Start  input  1  level request; sampled only in IDLE
- X  input  WIDTH  unsigned radicand; captured on the accepting edge, ignored afterwards
- Root  output  WIDTH/2  floor(sqrt(X)) of the last completed operation
- Rem  output  WIDTH/2+1  X − Root² of the last completed operation
- Done  output  1  high while in DONE
- Busy  output  1  high while in ITER
- state_out  output  2  present state: IDLE=2'b00, ITER=2'b01, DONE=2'b10 (2'b11 unused, decodes to IDLE)

## Operation
- State register, next-state logic and output decode are separate. All outputs are registered or a pure decode of state.
- IDLE → ITER on a clock edge with Start=1. On that edge the unit:
  - latches X into the shift register D
  - clears the working registers r (WIDTH/2+2 bits) and q (WIDTH/2 bits)
  - clears the iteration counter cnt (ceil(log2 N)+1 bits)
- ITER performs one restoring step per edge:
  - r' = {r[WIDTH/2−1:0], D[WIDTH−1:WIDTH−2]}
  - t = r' − {q, 2'b01}, computed at WIDTH/2+2 bits, sign taken from the borrow
  - if t ≥ 0: r ← t, q ← {q[WIDTH/2−2:0],1}
  - else: r ← r', q ← {q[WIDTH/2−2:0],0}
  - D ← D << 2; cnt ← cnt+1
- The ITER → DONE edge is the one performing iteration N (cnt == N−1 before the edge). On that edge:
  - Root ← final q; Rem ← final r[WIDTH/2:0]. r never exceeds 2·q, so the truncation is lossless.
- DONE → IDLE on an edge with Start=0. DONE holds while Start=1, so a caller holding Start high never retriggers.
- Start during ITER is ignored. X changes after capture are ignored.
- Root and Rem change only on the ITER → DONE edge and hold through IDLE until the next completion.
- CLR=1 at any time, including mid-ITER, asynchronously forces IDLE and zeroes Root, Rem, D, r, q and cnt. Any operation in progress is discarded with no Done.
- Unused state 2'b11 → IDLE on the next edge.

## Timing
- Reset values: Root=0, Rem=0, Done=0, Busy=0, state_out=2'b00.
- Accepting edge E0 (IDLE, Start=1): Busy=1 after E0.
- Iterations occur on edges E1..EN. Done=1 and Busy=0 after EN; Root and Rem are valid in the same cycle Done rises.
- Latency: N edges from the accepting edge to Done (8 for WIDTH=16). Minimum period between requests: N+2 cycles (accept, N iterations, one DONE cycle with Start low).
- Back-to-back: Start low for ≥1 edge in DONE returns the unit to IDLE. Start high on the next edge starts a new operation; the previous Root and Rem remain visible until the new completion.
- Done deasserts on the edge that leaves DONE.

## Test plan
- Reset: assert CLR asynchronously mid-cycle → all outputs 0 immediately, state_out=00; release, idle 5 cycles → still 0.
- WIDTH=16 correctness: X=0 → Root=0, Rem=0; X=144 → 12, 0; X=17 → 4, 1; X=65535 → 255, 510. Done rises exactly 8 edges after the accepting edge, Busy high for exactly 8 cycles.
- Handshake hold: Start held high through completion → unit remains in DONE for 10 cycles with no retrigger; drop Start → IDLE next edge, Done=0.
- Abort: start X=40000, assert CLR after 4 iterations → IDLE, Root=Rem=0, no Done. New start X=40000 → Root=200, Rem=0.
- Ignore rules: change X and pulse Start during ITER → result still matches the captured X (e.g. 99 → 9, 18).
- Parameter sweep with WIDTH=4 and WIDTH=32: exhaustive over all 16 values for WIDTH=4, random 1000 values for WIDTH=32 → Root²+Rem == X and Rem ≤ 2·Root. Latency is 2 and 16 edges respectively.

Source files
------------

// File: rtl/sqrt_seq_unit.sv
// Sequential restoring integer square root: one root bit per clock.
// Start/Done level handshake; Root/Rem hold the last completed result.
module sqrt_seq_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               CLR,
  input  logic               Start,
  input  logic [WIDTH-1:0]   X,
  output logic [WIDTH/2-1:0] Root,
  output logic [WIDTH/2:0]   Rem,
  output logic               Done,
  output logic               Busy,
  output logic [1:0]         state_out
);

  localparam int unsigned H     = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(H) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(H - 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("sqrt_seq_unit: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [H+1:0]     r_q, r_d;
  logic [H-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [H-1:0]     root_q, root_d;
  logic [H:0]       rem_q, rem_d;

  logic [H+1:0]     r_shift;
  logic [H+2:0]     diff;
  logic [H+1:0]     r_step;
  logic [H-1:0]     q_step;
  logic             last_iter;

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = Start ? ITER : IDLE;
      ITER:    state_d = last_iter ? DONE : ITER;
      DONE:    state_d = Start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Restoring step: the extra top bit of diff is the borrow, i.e. the sign of t
  always_comb begin
    r_shift   = {r_q[H-1:0], d_q[WIDTH-1 -: 2]};
    diff      = {1'b0, r_shift} - {1'b0, q_q, 2'b01};
    r_step    = diff[H+2] ? r_shift : diff[H+1:0];
    q_step    = {q_q[H-2:0], ~diff[H+2]};
    last_iter = (cnt_q == LAST);
  end

  always_comb begin
    d_d    = d_q;
    r_d    = r_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    root_d = root_q;
    rem_d  = rem_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          d_d   = X;
          r_d   = '0;
          q_d   = '0;
          cnt_d = '0;
        end
      end
      ITER: begin
        d_d   = d_q << 2;
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          root_d = q_step;
          rem_d  = r_step[H:0];
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  // Output decode
  always_comb begin
    Done      = (state_q == DONE);
    Busy      = (state_q == ITER);
    state_out = state_q;
    Root      = root_q;
    Rem       = rem_q;
  end

endmodule

// File: tb/tb_sqrt_seq_unit.sv
// Self-checking bench for sqrt_seq_unit at WIDTH=16, 4 and 32 against an
// arithmetic floor-sqrt reference.
module tb_sqrt_seq_unit;

  logic clk = 1'b0;
  logic clr;

  logic        s16, done16, busy16;
  logic [15:0] x16;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  logic [1:0]  st16;

  logic        s4, done4, busy4;
  logic [3:0]  x4;
  logic [1:0]  root4;
  logic [2:0]  rem4;
  logic [1:0]  st4;

  logic        s32, done32, busy32;
  logic [31:0] x32;
  logic [15:0] root32;
  logic [16:0] rem32;
  logic [1:0]  st32;

  int compared   = 0;
  int mismatched = 0;

  sqrt_seq_unit #(.WIDTH(16)) u16 (
    .clk(clk), .CLR(clr), .Start(s16), .X(x16), .Root(root16), .Rem(rem16),
    .Done(done16), .Busy(busy16), .state_out(st16));
  sqrt_seq_unit #(.WIDTH(4)) u4 (
    .clk(clk), .CLR(clr), .Start(s4), .X(x4), .Root(root4), .Rem(rem4),
    .Done(done4), .Busy(busy4), .state_out(st4));
  sqrt_seq_unit #(.WIDTH(32)) u32 (
    .clk(clk), .CLR(clr), .Start(s32), .X(x32), .Root(root32), .Rem(rem32),
    .Done(done32), .Busy(busy32), .state_out(st32));

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] root;
    logic [31:0] rem;
  } vec_t;

  vec_t tbl[26];

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic s, input logic [31:0] x);
    case (sel)
      0: begin s16 = s; x16 = x[15:0]; end
      1: begin s4 = s;  x4 = x[3:0];   end
      default: begin s32 = s; x32 = x; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done16;
      1: return done4;
      default: return done32;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy16;
      1: return busy4;
      default: return busy32;
    endcase
  endfunction

  function automatic logic [1:0] get_state(input int sel);
    case (sel)
      0: return st16;
      1: return st4;
      default: return st32;
    endcase
  endfunction

  function automatic logic [31:0] get_root(input int sel);
    case (sel)
      0: return 32'(root16);
      1: return 32'(root4);
      default: return 32'(root32);
    endcase
  endfunction

  function automatic logic [31:0] get_rem(input int sel);
    case (sel)
      0: return 32'(rem16);
      1: return 32'(rem4);
      default: return 32'(rem32);
    endcase
  endfunction

  // One full request: accept, iterate (X scrambled, optional Start pulse), return to IDLE
  task automatic op(input int sel, input logic [31:0] x, input bit pulse,
                    output logic [31:0] root, output logic [31:0] rem,
                    output int lat, output int busy_cyc);
    @(negedge clk);
    set_in(sel, 1'b1, x);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, $urandom);
    lat = 0;
    busy_cyc = 0;
    while (!get_done(sel) && lat < 200) begin
      if (get_busy(sel)) busy_cyc++;
      set_in(sel, pulse && (lat == 2), $urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("done_seen", get_done(sel), 1);
    root = get_root(sel);
    rem  = get_rem(sel);
    set_in(sel, 1'b0, $urandom);
    @(posedge clk);
    @(negedge clk);
    check("back_to_idle_state", get_state(sel), 0);
    check("back_to_idle_done", get_done(sel), 0);
    check("root_held_in_idle", get_root(sel), root);
  endtask

  initial begin
    logic [31:0] r, m, x;
    int lat, bc, k, bad;
    bit done_seen;
    longint unsigned er;

    clr = 1'b1;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    set_in(2, 1'b0, '0);

    tbl[0] = '{32'd0,     32'd0,   32'd0};
    tbl[1] = '{32'd144,   32'd12,  32'd0};
    tbl[2] = '{32'd17,    32'd4,   32'd1};
    tbl[3] = '{32'd65535, 32'd255, 32'd510};
    tbl[4] = '{32'd40000, 32'd200, 32'd0};
    tbl[5] = '{32'd99,    32'd9,   32'd18};
    for (int i = 6; i < 26; i++) begin
      x = 32'($urandom_range(65535));
      er = isqrt(64'(x));
      tbl[i] = '{x, 32'(er), 32'(64'(x) - er * er)};
    end

    #12;
    check("rst_root16", root16, 0);
    check("rst_rem16", rem16, 0);
    check("rst_done16", done16, 0);
    check("rst_busy16", busy16, 0);
    check("rst_state16", st16, 0);
    check("rst_state4", st4, 0);
    check("rst_state32", st32, 0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 26; i++) begin
      op(0, tbl[i].x, 1'b0, r, m, lat, bc);
      check($sformatf("root16[x=%0d]", tbl[i].x), r, tbl[i].root);
      check($sformatf("rem16[x=%0d]", tbl[i].x), m, tbl[i].rem);
      check("latency16", lat, 8);
      check("busy_cycles16", bc, 8);
    end

    // Asynchronous reset mid-cycle with a non-zero result on the outputs
    op(0, 32'd144, 1'b0, r, m, lat, bc);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("async_clr_root", root16, 0);
    check("async_clr_rem", rem16, 0);
    check("async_clr_state", st16, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    check("idle5_root", root16, 0);
    check("idle5_rem", rem16, 0);
    check("idle5_done", done16, 0);
    check("idle5_busy", busy16, 0);
    check("idle5_state", st16, 0);

    // Start held high through completion: no retrigger
    @(negedge clk);
    s16 = 1'b1;
    x16 = 16'd144;
    k = 0;
    while (!done16 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("hold_latency", k, 9);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(done16 && st16 == 2'b10 && !busy16)) bad++;
    end
    check("hold_in_done", bad, 0);
    check("hold_root", root16, 12);
    s16 = 1'b0;
    @(negedge clk);
    check("hold_release_state", st16, 0);
    check("hold_release_done", done16, 0);

    // Abort after 4 iterations
    s16 = 1'b1;
    x16 = 16'd40000;
    @(posedge clk);
    @(negedge clk);
    s16 = 1'b0;
    repeat (4) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("abort_state", st16, 0);
    check("abort_root", root16, 0);
    check("abort_rem", rem16, 0);
    @(negedge clk);
    clr = 1'b0;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done16) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 0);
    op(0, 32'd40000, 1'b0, r, m, lat, bc);
    check("after_abort_root", r, 200);
    check("after_abort_rem", m, 0);

    // Start pulse and X changes during ITER are ignored
    op(0, 32'd99, 1'b1, r, m, lat, bc);
    check("ignore_root", r, 9);
    check("ignore_rem", m, 18);
    check("ignore_latency", lat, 8);

    // WIDTH=4 exhaustive
    for (int v = 0; v < 16; v++) begin
      op(1, 32'(v), 1'b0, r, m, lat, bc);
      er = isqrt(64'(v));
      check($sformatf("root4[x=%0d]", v), r, longint'(er));
      check($sformatf("ident4[x=%0d]", v), longint'(r) * r + m, v);
      check($sformatf("rembound4[x=%0d]", v), longint'(m <= 2 * r), 1);
      check("latency4", lat, 2);
    end

    // WIDTH=32 random, plus the all-ones corner
    for (int i = 0; i < 1000; i++) begin
      x = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      op(2, x, 1'b0, r, m, lat, bc);
      er = isqrt(64'(x));
      check($sformatf("root32[x=%0d]", x), r, longint'(er));
      check($sformatf("ident32[x=%0d]", x), longint'(r) * longint'(r) + longint'(m), longint'(x));
      check($sformatf("rembound32[x=%0d]", x), longint'(64'(m) <= 64'(2) * 64'(r)), 1);
      check("latency32", lat, 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
